// File: rtl/capture_ram_pkg.sv
// capture_ram_pkg
//   Shared definitions for the ISA bus trace capture RAM: word and address
//   widths, field positions inside a capture word, and the encoded
//   chip-select values written by the acquisition FSM.
package capture_ram_pkg;

   localparam int unsigned CAPTURE_DATA_WIDTH = 26;
   localparam int unsigned CAPTURE_ADDR_WIDTH = 12;

   // Capture word layout: [25:23] cs, [22] io, [21] mem, [20] is16, [19:0] sa
   localparam int unsigned CS_MSB   = 25;
   localparam int unsigned CS_LSB   = 23;
   localparam int unsigned IO_BIT   = 22;
   localparam int unsigned MEM_BIT  = 21;
   localparam int unsigned W16_BIT  = 20;
   localparam int unsigned SA_MSB   = 19;
   localparam int unsigned SA_LSB   = 0;

   typedef enum logic [2:0] {
      CsIdle    = 3'd0,
      Cs0       = 3'd1,
      Cs1       = 3'd2,
      Cs2       = 3'd3,
      Cs3       = 3'd4,
      CsInvalid = 3'd7
   } csCode_e;

   typedef struct packed {
      csCode_e     cs;
      logic        io;
      logic        mem;
      logic        is16;
      logic [19:0] sa;
   } captureWord_t;

   function automatic logic [CAPTURE_DATA_WIDTH-1:0] packCapture(input captureWord_t w);
      return CAPTURE_DATA_WIDTH'(w);
   endfunction

endpackage

// File: rtl/capture_ram_outreg.sv
// capture_ram_outreg
//   Optional second read pipeline stage. Loads every clock; cleared
//   asynchronously by nReset.
// Ports:
//   Clock  - rising-edge clock
//   nReset - asynchronous active-low reset
//   d      - stage-1 read data
//   q      - registered read data
module capture_ram_outreg
   import capture_ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CAPTURE_DATA_WIDTH
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] stageQ;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         stageQ <= '0;
      end else begin
         stageQ <= d;
      end
   end

   assign q = stageQ;

endmodule

// File: rtl/capture_ram.sv
// capture_ram
//   Simple dual-port synchronous RAM holding captured ISA bus trace words.
//   The acquisition FSM writes through the write port; the host drains
//   through the read port. Reset clears only the read output path.
// Ports:
//   Clock     - rising-edge clock for both ports
//   nReset    - asynchronous active-low reset (read output registers only)
//   data      - write data
//   wraddress - write address
//   wren      - write enable, active high
//   rdaddress - read address
//   rden      - read enable, active high (gates the first read stage)
//   q         - read data, latency 1 (OUT_REG=0) or 2 (OUT_REG=1)
module capture_ram
   import capture_ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CAPTURE_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = CAPTURE_ADDR_WIDTH,
   parameter int unsigned DEPTH      = 4096,
   parameter int unsigned OUT_REG    = 0
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_WIDTH-1:0] wraddress,
   input  logic                  wren,
   input  logic [ADDR_WIDTH-1:0] rdaddress,
   input  logic                  rden,
   output logic [DATA_WIDTH-1:0] q
);

   if (DEPTH != (2 ** ADDR_WIDTH)) begin : gDepthCheck
      $error("capture_ram: DEPTH must equal 2**ADDR_WIDTH");
   end

   // Initialised contents give all-zero power-up state; no reset on the array
   // so it maps onto block RAM.
   logic [DATA_WIDTH-1:0] memArray [DEPTH] = '{default: '0};
   logic [DATA_WIDTH-1:0] rdQ;

   // Writes are dropped while nReset is low.
   always_ff @(posedge Clock) begin
      if (wren && nReset) begin
         memArray[wraddress] <= data;
      end
   end

   // Non-blocking read of the array gives old data on a same-address
   // read-during-write.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         rdQ <= '0;
      end else if (rden) begin
         rdQ <= memArray[rdaddress];
      end
   end

   if (OUT_REG != 0) begin : gOutReg
      capture_ram_outreg #(
         .DATA_WIDTH (DATA_WIDTH)
      ) uOutReg (
         .Clock  (Clock),
         .nReset (nReset),
         .d      (rdQ),
         .q      (q)
      );
   end else begin : gNoOutReg
      assign q = rdQ;
   end

endmodule

// File: tb/tb_capture_ram.sv
// tb_capture_ram
//   Self-checking bench for capture_ram. A reference memory model produces
//   the expected word when a read is issued; the expectation is queued with
//   the cycle it is due on and compared against q when that cycle arrives.
module tb_capture_ram;
   import capture_ram_pkg::*;

   parameter int unsigned OUT_REG = 0;
   localparam int LAT = (OUT_REG != 0) ? 2 : 1;

   logic        Clock = 1'b0;
   logic        nReset;
   logic [25:0] data;
   logic [11:0] wraddress;
   logic        wren;
   logic [11:0] rdaddress;
   logic        rden;
   logic [25:0] q;

   logic [25:0] model [4096];
   logic [25:0] expQ [$];
   int          dueQ [$];
   int          edgeCount  = 0;
   int          checkCount = 0;
   int          errCount   = 0;

   capture_ram #(
      .DATA_WIDTH (26),
      .ADDR_WIDTH (12),
      .DEPTH      (4096),
      .OUT_REG    (OUT_REG)
   ) dut (
      .Clock     (Clock),
      .nReset    (nReset),
      .data      (data),
      .wraddress (wraddress),
      .wren      (wren),
      .rdaddress (rdaddress),
      .rden      (rden),
      .q         (q)
   );

   always #5 Clock = ~Clock;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic checkEq(input string tag, input logic [25:0] got, input logic [25:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // One clock: model the edge, then compare any reads that are due.
   task automatic tick(input string tag);
      logic [25:0] e;
      @(posedge Clock);
      edgeCount++;
      if (nReset) begin
         if (rden) begin
            expQ.push_back(model[rdaddress]);
            dueQ.push_back(edgeCount + LAT - 1);
         end
         if (wren) model[wraddress] = data;
      end
      #1;
      while (dueQ.size() > 0 && dueQ[0] == edgeCount) begin
         void'(dueQ.pop_front());
         e = expQ.pop_front();
         checkEq(tag, q, e);
      end
   endtask

   task automatic idle(input int n);
      wren = 1'b0;
      rden = 1'b0;
      for (int i = 0; i < n; i++) tick("drain");
   endtask

   task automatic wr(input logic [11:0] a, input logic [25:0] d);
      wren = 1'b1; wraddress = a; data = d; rden = 1'b0;
      tick("write");
      wren = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, input string tag);
      rden = 1'b1; rdaddress = a; wren = 1'b0;
      tick(tag);
      rden = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) model[i] = '0;
      nReset = 1'b0; data = '0; wraddress = '0; wren = 1'b0; rdaddress = '0; rden = 1'b0;
      #3;
      checkEq("reset_q", q, 26'h0);
      #9 nReset = 1'b1;

      // Power-up contents
      rd(12'h005, "powerup_005");
      rd(12'hFFF, "powerup_fff");
      rd(12'h010, "powerup_010");
      rd(12'h000, "powerup_000");
      idle(LAT);
      checkEq("powerup_q", q, 26'h0);

      // 1: write then read
      wr(12'h005, 26'h3ABCDE);
      rd(12'h005, "wr_rd_005");
      idle(LAT);
      checkEq("wr_rd_const", q, 26'h3ABCDE);

      // 2: read-during-write same address
      wr(12'h010, 26'h0000001);
      rden = 1'b1; rdaddress = 12'h010;
      wren = 1'b1; wraddress = 12'h010; data = 26'h2222222;
      tick("rdw_old");
      wren = 1'b0; rden = 1'b0;
      idle(LAT);
      checkEq("rdw_old_const", q, 26'h0000001);
      rd(12'h010, "rdw_new");
      idle(LAT);
      checkEq("rdw_new_const", q, 26'h2222222);

      // 3: boundary addresses
      wr(12'hFFF, 26'h1555555);
      wr(12'h000, 26'h0AAAAAA);
      rd(12'hFFF, "bound_fff");
      rd(12'h000, "bound_000");
      idle(LAT);
      checkEq("bound_000_const", q, 26'h0AAAAAA);
      rd(12'hFFF, "bound_fff2");
      idle(LAT);
      checkEq("bound_fff_const", q, 26'h1555555);

      // 4: rden=0 holds q
      rd(12'h005, "hold_rd");
      idle(LAT);
      rden = 1'b0; rdaddress = 12'hFFF;
      tick("hold"); tick("hold"); tick("hold");
      checkEq("hold_q", q, 26'h3ABCDE);

      // 5: asynchronous reset between edges, writes ignored while low
      #2 nReset = 1'b0;
      #1 checkEq("async_reset_q", q, 26'h0);
      wren = 1'b1; wraddress = 12'h005; data = 26'h1111111;
      rden = 1'b1; rdaddress = 12'h005;
      tick("in_reset"); tick("in_reset");
      checkEq("reset_hold_q", q, 26'h0);
      wren = 1'b0; rden = 1'b0;
      #2 nReset = 1'b1;
      rd(12'h005, "post_reset_005");
      idle(LAT);
      checkEq("post_reset_const", q, 26'h3ABCDE);

      // 6: full sweep, pipelined readback
      for (int i = 0; i < 4096; i++) wr(12'(i), 26'(i) ^ 26'h1234567);
      for (int i = 0; i < 4096; i++) begin
         rden = 1'b1; rdaddress = 12'(i);
         tick("sweep");
      end
      idle(LAT);
      checkEq("sweep_last_const", q, 26'hFFF ^ 26'h1234567);

      checkEq("queue_empty", 26'(expQ.size()), 26'h0);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
